ham_dec: RTL
============

// Module: ham_dec
// PURPOSE
//  Hamming(7,4) single-error-correcting decoder. It is the receive-side counterpart of the Ham encoder.
//  Takes 7-bit codewords over a valid/ready stream and corrects any single-bit error.
//  Emits the 4-bit data word, the 3-bit syndrome and an error flag through a 2-stage pipeline.
//  Sits between the channel/link model and the consumer of the original 4-bit data.
// PARAMETERS
//  CNT_W   16   width of the corrected-word counter (used only when HAM_DEC_ERR_CNT_EN is defined)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_code holds a codeword
//  in_ready   out  1      decoder accepts in_code this cycle
//  in_code    in   7      received codeword; bit i = Hamming position i+1
//  out_valid  out  1      out_* fields hold a decoded word
//  out_ready  in   1      consumer accepts the word this cycle
//  out_dat    out  4      corrected data {d4,d3,d2,d1}
//  out_syn    out  3      syndrome {s4,s2,s1}; 0 = no error
//  out_err    out  1      1 = nonzero syndrome (a bit was corrected)
//  corr_cnt   out  CNT_W  number of corrected words delivered
// BEHAVIOUR
//  - Code layout: pos1..7 = p1 p2 d1 p4 d2 d3 d4, so in_code[6:0] = {d4,d3,d2,p4,d1,p2,p1}.
//    Parity bits:
//      p1 = d1^d2^d4
//      p2 = d1^d3^d4
//      p4 = d2^d3^d4
//  - Syndrome bits:
//      s1 = c[0]^c[2]^c[4]^c[6]
//      s2 = c[1]^c[2]^c[5]^c[6]
//      s4 = c[3]^c[4]^c[5]^c[6]
//  - Correction: if syn != 0, invert c[syn-1] before extracting d1..d4. Flipped parity bits (syn 1,2,4) leave data unchanged.
//  - Double errors are undetectable in (7,4) and are miscorrected; this is not flagged.
//  - Pipeline:
//      S1 registers in_code and a valid bit.
//      S2 computes syndrome/correction and registers the out_* fields.
//  - Advance enable: en = ~out_valid | out_ready. in_ready = en.
//      - When en=1, both stages shift; S1 takes in_valid&in_ready.
//      - When en=0, both stages hold.
//  - Latency: 2 cycles from accept to out_valid when unstalled; throughput 1 word/cycle.
//  - out_* remain stable while out_valid=1 & out_ready=0. No word is dropped or duplicated.
//  - Bubbles: a cycle with in_valid=0 propagates as out_valid=0 two cycles later.
//  - Reset values: out_valid=0, out_dat=0, out_syn=0, out_err=0, corr_cnt=0, S1 valid=0. in_ready=1 during and after reset.
//  - Reset mid-operation discards all in-flight words. The first output after rst deasserts comes from a post-reset input.
//  - Simultaneous out transfer and new accept in the same cycle is legal (full streaming).
// CONFIGURATION
//  HAM_DEC_ERR_CNT_EN
//  - Defined: corr_cnt increments on each out_valid & out_ready & out_err.
//    It saturates at 2^CNT_W-1 and is cleared only by rst.
//  - Undefined: no counter logic is built and corr_cnt is driven constant 0.
//    All other behaviour is identical.
// TESTING
//  1. Clean words 7'b0101101, 7'b1100110, 7'b1111111 with out_ready=1.
//     -> out_dat 4'b0101, 4'b1101, 4'b1111; out_syn=0; out_err=0.
//     -> Each word appears 2 cycles after its accept.
//  2. 7'b0101001 (d1 flipped) -> out_dat=4'b0101, out_syn=3'b011, out_err=1.
//     7'b0101100 (p1 flipped) -> out_dat=4'b0101, out_syn=3'b001.
//  3. Exhaustive sweep: all 16 data values x {no error, each of 7 single flips}.
//     -> out_dat always equals the data value; out_syn equals the flipped position, or 0 with no flip.
//  4. Stream 8 words with out_ready held 0 for 5 cycles mid-stream.
//     -> in_ready drops to 0; out_* held stable; all 8 words delivered in order with none lost.
//  5. Assert rst for 1 cycle with 2 words in flight.
//     -> out_valid=0 the next cycle; those words never appear; corr_cnt=0.
//  6. With HAM_DEC_ERR_CNT_EN and CNT_W=2, deliver 5 corrected words.
//     -> corr_cnt reads 1,2,3,3,3.
//     Without the macro, corr_cnt stays 0.

Source files
------------

// File: rtl/ham_dec.sv
`default_nettype none
// ============================================================================
//  Module      : ham_dec
//  Description : Hamming(7,4) single-error-correcting decoder with a 2-stage
//                valid/ready pipeline.
//                S1 registers the received codeword and its valid bit.
//                S2 computes the syndrome, corrects a single flipped bit and
//                registers the data, syndrome and error flag.
//                Both stages advance together whenever the output register
//                is empty or being consumed (en = ~out_valid | out_ready).
//  Ports       : clk, rst          clock, synchronous active-high reset
//                in_valid/in_ready input handshake, in_code[6:0] codeword
//                                  ({d4,d3,d2,p4,d1,p2,p1}, bit i = pos i+1)
//                out_valid/out_ready output handshake
//                out_dat[3:0]      corrected data {d4,d3,d2,d1}
//                out_syn[2:0]      syndrome {s4,s2,s1}, 0 = clean word
//                out_err           nonzero syndrome (a bit was corrected)
//                corr_cnt[CNT_W-1:0] saturating count of delivered corrected
//                                  words
//  Config      : HAM_DEC_ERR_CNT_EN - when defined, builds the corrected-word
//                counter; otherwise corr_cnt is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module ham_dec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_dat,
    output logic [2:0]       out_syn,
    output logic             out_err,
    output logic [CNT_W-1:0] corr_cnt
);

    logic       w_en;
    logic       r_s1_valid;
    logic [6:0] r_s1_code;
    logic [2:0] w_syn;
    logic [6:0] w_fixed;

    // The whole pipeline moves as one: it only stalls when the output
    // register holds a word the consumer has not taken yet.
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    // Stage 1: capture codeword
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= 7'd0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_code  <= in_code;
        end
    end

    // Syndrome: each bit is the parity over the positions whose index has
    // that bit set, so the syndrome value is the 1-based error position.
    assign w_syn[0] = r_s1_code[0] ^ r_s1_code[2] ^ r_s1_code[4] ^ r_s1_code[6];
    assign w_syn[1] = r_s1_code[1] ^ r_s1_code[2] ^ r_s1_code[5] ^ r_s1_code[6];
    assign w_syn[2] = r_s1_code[3] ^ r_s1_code[4] ^ r_s1_code[5] ^ r_s1_code[6];

    // Invert the bit at position syn (index syn-1); syn=0 matches nothing.
    always_comb begin
        w_fixed = r_s1_code;
        for (int i = 0; i < 7; i++) begin
            if (w_syn == 3'(i + 1)) begin
                w_fixed[i] = ~r_s1_code[i];
            end
        end
    end

    // Stage 2: register decoded fields
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dat   <= 4'd0;
            out_syn   <= 3'd0;
            out_err   <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_s1_valid;
            out_dat   <= {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
            out_syn   <= w_syn;
            out_err   <= (w_syn != 3'd0);
        end
    end

`ifdef HAM_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] r_corr_cnt;

    // Counts words that actually leave the decoder with a correction applied;
    // holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_corr_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (r_corr_cnt != '1)) begin
            r_corr_cnt <= r_corr_cnt + CNT_W'(1);
        end
    end

    assign corr_cnt = r_corr_cnt;
`else
    assign corr_cnt = '0;
`endif

endmodule
`default_nettype wire
